ccff_chain_ctrl: RTL and testbench

- Configuration-chain loader for the FPGA fabric.
- Accepts bitstream words over a valid/ready stream and serializes them into the head of the sc_dff_compact configuration chain.
- Gates the chain shift, one bit per shift cycle, and reports completion.
- Sits between the bitstream source (JTAG/SPI bridge or testbench) and the fabric chain head.

---
 rtl/ccff_chain_ctrl_pkg.sv | 22 ++
 rtl/ccff_chain_ctrl_if.sv | 20 ++
 rtl/ccff_chain_ctrl_crc16.sv | 39 +++
 rtl/ccff_chain_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ccff_chain_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_ctrl_pkg.sv
// Shared types and constants for the configuration-chain loader.
// CRC constants are used only when CCFF_CHAIN_CRC_EN is defined.
package ccff_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WORD = 2'd1,
        SHIFT     = 2'd2,
        DONE      = 2'd3
    } ccff_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT step for a single serial bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_chain_ctrl_if.sv
// Bitstream word stream (valid/ready) from the source into the chain loader.
interface ccff_chain_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_chain_ctrl_crc16.sv
// Serial CRC-16-CCITT accumulator over the bits driven into the chain head.
// Present only in builds with CCFF_CHAIN_CRC_EN defined.
`ifdef CCFF_CHAIN_CRC_EN
module ccff_crc16
    import ccff_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc_next
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CRC16_INIT;
        end else if (en) begin
            crc_d = crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    // Exposes the post-update value so the final bit is included at DONE entry.
    assign crc_next = crc_d;

endmodule
`endif

// File: rtl/ccff_chain_ctrl.sv
// Loads bitstream words into the configuration chain head, one bit per shift_en cycle.
// Optional CRC check of the shifted stream: define CCFF_CHAIN_CRC_EN.
//   state     | meaning
//   IDLE      | no load since reset
//   LOAD_WORD | cfg_ready high, waiting for the next word; chain holds
//   SHIFT     | one bit presented on ccff_head per cycle with shift_en high
//   DONE      | all CHAIN_LEN bits shifted; done held until next start
module ccff_chain_ctrl
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    ccff_chain_ctrl_if.slave  cfg,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
`ifdef CCFF_CHAIN_CRC_EN
    ,
    input  logic [15:0]       crc_exp,
    output logic              crc_ok,
    output logic              crc_err
`endif
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int NB_W  = $clog2(WORD_W + 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_LOAD  = LOAD_WORD;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]        state_q,     state_d;
    logic [CNT_W-1:0]  bits_left_q, bits_left_d;
    logic [NB_W-1:0]   nbits_q,     nbits_d;
    logic [WORD_W-1:0] sreg_q,      sreg_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              head_q,      head_d;
    logic              shift_en_q,  shift_en_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    // The tail is reserved for a read-back check; the loader itself never looks at it.
    logic tail_unused;
    assign tail_unused = ccff_tail;

    // Counters track bits not yet clocked into the chain, including the one on ccff_head.
    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        nbits_d     = nbits_q;
        sreg_d      = sreg_q;
        cfg_ready_d = cfg_ready_q;
        head_d      = head_q;
        shift_en_d  = shift_en_q;
        busy_d      = busy_q;
        done_d      = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    bits_left_d = CNT_W'(CHAIN_LEN);
                    cfg_ready_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                end
            end
            S_LOAD: begin
                if (cfg.cfg_valid && cfg_ready_q) begin
                    state_d     = S_SHIFT;
                    head_d      = cfg.cfg_data[WORD_W-1];
                    sreg_d      = cfg.cfg_data << 1;
                    shift_en_d  = 1'b1;
                    cfg_ready_d = 1'b0;
                    if (32'(bits_left_q) >= WORD_W) begin
                        nbits_d = NB_W'(WORD_W);
                    end else begin
                        nbits_d = NB_W'(bits_left_q);
                    end
                end
            end
            S_SHIFT: begin
                bits_left_d = bits_left_q - CNT_W'(1);
                nbits_d     = nbits_q - NB_W'(1);
                if (bits_left_q == CNT_W'(1)) begin
                    state_d    = S_DONE;
                    shift_en_d = 1'b0;
                    head_d     = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (nbits_q == NB_W'(1)) begin
                    state_d     = S_LOAD;
                    shift_en_d  = 1'b0;
                    head_d      = 1'b0;
                    cfg_ready_d = 1'b1;
                end else begin
                    head_d = sreg_q[WORD_W-1];
                    sreg_d = sreg_q << 1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bits_left_q <= '0;
            nbits_q     <= '0;
            sreg_q      <= '0;
            cfg_ready_q <= 1'b0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            nbits_q     <= nbits_d;
            sreg_q      <= sreg_d;
            cfg_ready_q <= cfg_ready_d;
            head_q      <= head_d;
            shift_en_q  <= shift_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg.cfg_ready  = cfg_ready_q;
    assign ccff_head      = head_q;
    assign ccff_shift_en  = shift_en_q;
    assign busy           = busy_q;
    assign done           = done_q;

`ifdef CCFF_CHAIN_CRC_EN
    logic [15:0] crc_next;
    logic        crc_init;
    logic        crc_en;
    logic        crc_ok_q,  crc_ok_d;
    logic        crc_err_q, crc_err_d;

    assign crc_init = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign crc_en   = (state_q == S_SHIFT);

    ccff_crc16 u_crc16 (
        .clk      (clk),
        .reset    (reset),
        .init     (crc_init),
        .en       (crc_en),
        .bit_in   (head_q),
        .crc_next (crc_next)
    );

    // Verdict is taken on the edge that enters DONE, so the last bit is included.
    always_comb begin
        crc_ok_d  = crc_ok_q;
        crc_err_d = crc_err_q;
        if (crc_init) begin
            crc_ok_d  = 1'b0;
            crc_err_d = 1'b0;
        end else if (crc_en && (bits_left_q == CNT_W'(1))) begin
            crc_ok_d  = (crc_next == crc_exp);
            crc_err_d = (crc_next != crc_exp);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_ok_q  <= 1'b0;
            crc_err_q <= 1'b0;
        end else begin
            crc_ok_q  <= crc_ok_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_ok  = crc_ok_q;
    assign crc_err = crc_err_q;
`endif

endmodule

// File: tb/tb_ccff_chain_ctrl.sv
// Directed bench for ccff_chain_ctrl: a 20-bit and a 16-bit chain loader, expected head bits scoreboarded.
module tb_ccff_chain_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start20, start16;
    logic head20, sh20, busy20, done20;
    logic head16, sh16, busy16, done16;

    ccff_chain_ctrl_if #(.WORD_W(8)) if20 ();
    ccff_chain_ctrl_if #(.WORD_W(8)) if16 ();

`ifdef CCFF_CHAIN_CRC_EN
    logic [15:0] crc_exp20, crc_exp16;
    logic        crc_ok20, crc_err20, crc_ok16, crc_err16;
`endif

    ccff_chain_ctrl #(.CHAIN_LEN(20), .WORD_W(8)) u20 (
        .clk           (clk),
        .reset         (reset),
        .start         (start20),
        .cfg           (if20),
        .ccff_head     (head20),
        .ccff_shift_en (sh20),
        .ccff_tail     (1'b0),
        .busy          (busy20),
        .done          (done20)
`ifdef CCFF_CHAIN_CRC_EN
        ,
        .crc_exp       (crc_exp20),
        .crc_ok        (crc_ok20),
        .crc_err       (crc_err20)
`endif
    );

    ccff_chain_ctrl #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
        .clk           (clk),
        .reset         (reset),
        .start         (start16),
        .cfg           (if16),
        .ccff_head     (head16),
        .ccff_shift_en (sh16),
        .ccff_tail     (1'b0),
        .busy          (busy16),
        .done          (done16)
`ifdef CCFF_CHAIN_CRC_EN
        ,
        .crc_exp       (crc_exp16),
        .crc_ok        (crc_ok16),
        .crc_err       (crc_err16)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit q20[$];
    bit q16[$];
    int rem20 = 0;
    int rem16 = 0;
    int sh_cnt20 = 0;
    int sh_cnt16 = 0;
    bit e20, e16;

    // Scoreboard: every shift cycle pops the next expected head bit.
    always @(negedge clk) begin
        if (sh20) begin
            sh_cnt20++;
            n_tests++;
            if (q20.size() == 0) begin
                n_fail++;
                $error("FAIL head20_extra: observed shift %0d, required no shift", sh_cnt20);
            end else begin
                e20 = q20.pop_front();
                assert (head20 === e20) else begin
                    n_fail++;
                    $error("FAIL head20 bit %0d: observed %b, required %b", sh_cnt20, head20, e20);
                end
            end
        end
        if (sh16) begin
            sh_cnt16++;
            n_tests++;
            if (q16.size() == 0) begin
                n_fail++;
                $error("FAIL head16_extra: observed shift %0d, required no shift", sh_cnt16);
            end else begin
                e16 = q16.pop_front();
                assert (head16 === e16) else begin
                    n_fail++;
                    $error("FAIL head16 bit %0d: observed %b, required %b", sh_cnt16, head16, e16);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input bit sel, input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            if (sel) begin
                if (rem16 > 0) begin q16.push_back(d[i]); rem16--; end
            end else begin
                if (rem20 > 0) begin q20.push_back(d[i]); rem20--; end
            end
        end
    endtask

    task automatic send_word(input bit sel, input logic [7:0] d);
        int   n;
        logic rdy;
        push_word(sel, d);
        if (sel) begin if16.cfg_data = d; if16.cfg_valid = 1'b1; end
        else     begin if20.cfg_data = d; if20.cfg_valid = 1'b1; end
        n   = 0;
        rdy = sel ? if16.cfg_ready : if20.cfg_ready;
        while (rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            rdy = sel ? if16.cfg_ready : if20.cfg_ready;
        end
        check("handshake_ready", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        #1;
        if (sel) if16.cfg_valid = 1'b0;
        else     if20.cfg_valid = 1'b0;
    endtask

    task automatic do_start(input bit sel, input bit fresh);
        if (fresh) begin
            if (sel) rem16 = 16; else rem20 = 20;
        end
        @(negedge clk);
        if (sel) start16 = 1'b1; else start20 = 1'b1;
        @(negedge clk);
        if (sel) start16 = 1'b0; else start20 = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int   n;
        logic d;
        n = 0;
        d = sel ? done16 : done20;
        while (d !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
            d = sel ? done16 : done20;
        end
        check(sel ? "done16_reached" : "done20_reached", {31'd0, d}, 32'd1);
    endtask

`ifdef CCFF_CHAIN_CRC_EN
    function automatic logic [15:0] crc_ref(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? b0 : b1;
            c = c ^ {b, 8'h00};
            for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction
`endif

    int gap_bad;
    int bcnt;
    int hold_bad;

    initial begin
        reset = 1'b1;
        start20 = 1'b0; start16 = 1'b0;
        if20.cfg_valid = 1'b0; if20.cfg_data = 8'h00;
        if16.cfg_valid = 1'b0; if16.cfg_data = 8'h00;
`ifdef CCFF_CHAIN_CRC_EN
        crc_exp20 = 16'h0000;
        crc_exp16 = crc_ref(8'h31, 8'h32);
`endif
        repeat (2) @(negedge clk);
        check("rst_ready",    {31'd0, if20.cfg_ready}, 32'd0);
        check("rst_head",     {31'd0, head20},         32'd0);
        check("rst_shift_en", {31'd0, sh20},           32'd0);
        check("rst_busy",     {31'd0, busy20},         32'd0);
        check("rst_done",     {31'd0, done20},         32'd0);
        reset = 1'b0;

        // Back-to-back load; last word keeps only its top nibble.
        sh_cnt20 = 0;
        do_start(0, 1);
        check("a_busy_after_start",  {31'd0, busy20},         32'd1);
        check("a_ready_after_start", {31'd0, if20.cfg_ready}, 32'd1);
        check("a_shen_after_start",  {31'd0, sh20},           32'd0);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        send_word(0, 8'hF0);
        wait_done(0);
        check("a_shift_count", sh_cnt20,       32'd20);
        check("a_queue_left",  q20.size(),     32'd0);
        check("a_busy_end",    {31'd0, busy20}, 32'd0);
        check("a_ready_end",   {31'd0, if20.cfg_ready}, 32'd0);

        // Source stalls 10 cycles before word 2: chain must hold.
        sh_cnt20 = 0;
        do_start(0, 1);
        check("b_done_cleared", {31'd0, done20}, 32'd0);
        send_word(0, 8'hA5);
        bcnt = 0;
        while (if20.cfg_ready !== 1'b1 && bcnt < 50) begin @(negedge clk); bcnt++; end
        gap_bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (sh20 !== 1'b0 || if20.cfg_ready !== 1'b1) gap_bad++;
        end
        check("b_gap_hold", gap_bad, 32'd0);
        send_word(0, 8'h3C);
        send_word(0, 8'hF0);
        wait_done(0);
        check("b_shift_count", sh_cnt20,   32'd20);
        check("b_queue_left",  q20.size(), 32'd0);

        // start while busy is ignored.
        sh_cnt20 = 0;
        do_start(0, 1);
        send_word(0, 8'hA5);
        do_start(0, 0);
        check("c_busy_after_restart", {31'd0, busy20}, 32'd1);
        send_word(0, 8'h3C);
        check("c_not_done_early", {31'd0, done20}, 32'd0);
        send_word(0, 8'hF0);
        wait_done(0);
        check("c_shift_count", sh_cnt20,   32'd20);
        check("c_queue_left",  q20.size(), 32'd0);

        // Asynchronous reset while bit 9 is on the head.
        sh_cnt20 = 0;
        do_start(0, 1);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        check("d_shen_at_bit9", {31'd0, sh20}, 32'd1);
        #2;
        reset = 1'b1;
        q20.delete();
        rem20 = 0;
        #1;
        check("d_rst_ready",    {31'd0, if20.cfg_ready}, 32'd0);
        check("d_rst_head",     {31'd0, head20},         32'd0);
        check("d_rst_shift_en", {31'd0, sh20},           32'd0);
        check("d_rst_busy",     {31'd0, busy20},         32'd0);
        check("d_rst_done",     {31'd0, done20},         32'd0);
        check("d_shifts_before_rst", sh_cnt20, 32'd8);
        @(negedge clk);
        reset = 1'b0;
        sh_cnt20 = 0;
        do_start(0, 1);
        send_word(0, 8'hA5);
        send_word(0, 8'h3C);
        send_word(0, 8'hF0);
        wait_done(0);
        check("d_reload_shift_count", sh_cnt20,   32'd20);
        check("d_reload_queue_left",  q20.size(), 32'd0);

        // 16-bit chain, exact multiple of the word size.
        sh_cnt16 = 0;
        do_start(1, 1);
        fork
            begin
                send_word(1, 8'h31);
                send_word(1, 8'h32);
            end
            begin
                bcnt = 0;
                while (busy16 === 1'b1 && bcnt < 100) begin bcnt++; @(negedge clk); end
            end
        join
        check("e_busy_cycles", bcnt, 32'd18);
        wait_done(1);
        check("e_shift_count", sh_cnt16, 32'd16);
`ifdef CCFF_CHAIN_CRC_EN
        check("e_crc_ok",  {31'd0, crc_ok16},  32'd1);
        check("e_crc_err", {31'd0, crc_err16}, 32'd0);
        crc_exp16 = 16'h0000;
`endif
        hold_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done16 !== 1'b1) hold_bad++;
        end
        check("e_done_held", hold_bad, 32'd0);
        sh_cnt16 = 0;
        do_start(1, 1);
        check("e_done_cleared", {31'd0, done16}, 32'd0);
        check("e_busy_again",   {31'd0, busy16}, 32'd1);
`ifdef CCFF_CHAIN_CRC_EN
        check("e_crc_ok_cleared", {31'd0, crc_ok16}, 32'd0);
`endif
        send_word(1, 8'h31);
        send_word(1, 8'h32);
        wait_done(1);
        check("e2_shift_count", sh_cnt16,   32'd16);
        check("e2_queue_left",  q16.size(), 32'd0);
`ifdef CCFF_CHAIN_CRC_EN
        check("e2_crc_ok",  {31'd0, crc_ok16},  32'd0);
        check("e2_crc_err", {31'd0, crc_err16}, 32'd1);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
